// File: rtl/trdp_eth_pkg.sv
// Shared TRDP/Ethernet constants and scheduler types for the udp_tx front end.
package trdp_eth_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_BUSY  = 4'b0100,
    ST_GAP   = 4'b1000
  } sched_state_e;

  localparam int ETH_MIN_PAYLOAD = 18;
  localparam int UDP_MAX_PAYLOAD = 1472;
  localparam int IFG_DEFAULT     = 12;

  function automatic logic len_ok(input logic [15:0] n, input int max_bytes);
    return (n != 16'd0) && (int'(n) <= max_bytes);
  endfunction

  function automatic logic [1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/udp_tx_sched_if.sv
// Scheduler <-> udp_tx frame engine link: start strobe, frame header and byte stream.
interface udp_tx_sched_if;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [47:0] des_mac;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_done;

  modport master (output tx_start_en, tx_byte_num, des_mac, tx_data,
                  input  tx_req, tx_done);
  modport slave  (input  tx_start_en, tx_byte_num, des_mac, tx_data,
                  output tx_req, tx_done);
endinterface

// File: rtl/udp_tx_sched.sv
// Two-channel scheduler (ch0 = TRDP process data, ch1 = message data) in front of udp_tx:
// arbitration, length check, start pulse, byte routing, inter-frame gap and hung-engine timeout.
module udp_tx_sched
  import trdp_eth_pkg::*;
#(
  parameter bit RR_EN          = 1'b1,
  parameter int START_HOLD     = 4,
  parameter int IFG_CYCLES     = IFG_DEFAULT,
  parameter int MAX_BYTES      = UDP_MAX_PAYLOAD,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch0_req,
  input  logic [15:0] ch0_byte_num,
  input  logic [47:0] ch0_des_mac,
  input  logic [7:0]  ch0_data,
  output logic        ch0_rd_en,
  output logic        ch0_done,
  output logic        ch0_err,
  input  logic        ch1_req,
  input  logic [15:0] ch1_byte_num,
  input  logic [47:0] ch1_des_mac,
  input  logic [7:0]  ch1_data,
  output logic        ch1_rd_en,
  output logic        ch1_done,
  output logic        ch1_err,
  udp_tx_sched_if.master eng,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int CNT_MAX = (START_HOLD > IFG_CYCLES) ? START_HOLD : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [15:0]      byte_num_q, byte_num_d;
  logic [47:0]      mac_q, mac_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             rr_prio_q, rr_prio_d;

  logic             win;
  logic [15:0]      win_bytes;
  logic [47:0]      win_mac;
  logic             start_en;
  logic [7:0]       data_mux;

  // On a tie the favoured channel wins; rr_prio_q points at the channel not served last.
  always_comb begin
    win       = (ch0_req && ch1_req) ? (RR_EN && rr_prio_q) : ~ch0_req;
    win_bytes = win ? ch1_byte_num : ch0_byte_num;
    win_mac   = win ? ch1_des_mac  : ch0_des_mac;
  end

  // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      byte_num_q <= '0;
      mac_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      rr_prio_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      byte_num_q <= byte_num_d;
      mac_q      <= mac_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      rr_prio_q  <= rr_prio_d;
    end
  end

  // NOTE: every value is defaulted before the case so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = '0;
    byte_num_d = byte_num_q;
    mac_d      = mac_q;
    cnt_d      = cnt_q;
    to_d       = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
    rr_prio_d  = rr_prio_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ch0_req || ch1_req) begin
          byte_num_d = win_bytes;
          mac_d      = win_mac;
          cnt_d      = '0;
          to_d       = '0;
          if (len_ok(win_bytes, MAX_BYTES)) begin
            grant_d = ch_onehot(win);
            state_d = ST_START;
          end else begin
            err_d   = ch_onehot(win);
            state_d = ST_GAP;
          end
        end
      end
      ST_START: begin
        if (cnt_q == CNT_W'(START_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        // A completion landing on the expiry cycle still counts as success.
        if (eng.tx_done) begin
          done_d    = grant_q;
          rr_prio_d = ~grant_q[1];
          grant_d   = '0;
          cnt_d     = '0;
          state_d   = ST_GAP;
        end else if (to_q == TO_MAX) begin
          err_d   = grant_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    start_en  = (state_q == ST_START);
    busy      = (state_q != ST_IDLE);
    ch0_rd_en = eng.tx_req & grant_q[0];
    ch1_rd_en = eng.tx_req & grant_q[1];
    if (grant_q[0])      data_mux = ch0_data;
    else if (grant_q[1]) data_mux = ch1_data;
    else                 data_mux = 8'h00;
  end

  assign eng.tx_start_en = start_en;
  assign eng.tx_byte_num = byte_num_q;
  assign eng.des_mac     = mac_q;
  assign eng.tx_data     = data_mux;
  assign grant           = grant_q;
  assign ch0_done        = done_q[0];
  assign ch1_done        = done_q[1];
  assign ch0_err         = err_q[0];
  assign ch1_err         = err_q[1];

endmodule

// File: tb/tb_udp_tx_sched.sv
// Self-checking bench for udp_tx_sched: frame table, round-robin/fixed arbitration, timeout and reset.
module tb_udp_tx_sched;
  import trdp_eth_pkg::*;

  localparam int IFG  = 12;
  localparam int HOLD = 4;
  localparam int TO   = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ch0_req, ch1_req;
  logic [15:0] ch0_byte_num, ch1_byte_num;
  logic [47:0] ch0_des_mac, ch1_des_mac;
  logic [7:0]  ch0_data, ch1_data;
  logic        ch0_rd_en, ch0_done, ch0_err;
  logic        ch1_rd_en, ch1_done, ch1_err;
  logic [1:0]  grant;
  logic        busy;

  logic        fp_req0, fp_req1;
  logic        fp_rd0, fp_done0, fp_err0, fp_rd1, fp_done1, fp_err1;
  logic [1:0]  fp_grant;
  logic        fp_busy;

  udp_tx_sched_if eif();
  udp_tx_sched_if fp_if();

  udp_tx_sched #(.RR_EN(1'b1), .START_HOLD(HOLD), .IFG_CYCLES(IFG), .MAX_BYTES(1472),
                 .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_req(ch0_req), .ch0_byte_num(ch0_byte_num), .ch0_des_mac(ch0_des_mac), .ch0_data(ch0_data),
    .ch0_rd_en(ch0_rd_en), .ch0_done(ch0_done), .ch0_err(ch0_err),
    .ch1_req(ch1_req), .ch1_byte_num(ch1_byte_num), .ch1_des_mac(ch1_des_mac), .ch1_data(ch1_data),
    .ch1_rd_en(ch1_rd_en), .ch1_done(ch1_done), .ch1_err(ch1_err),
    .eng(eif), .grant(grant), .busy(busy)
  );

  udp_tx_sched #(.RR_EN(1'b0), .START_HOLD(HOLD), .IFG_CYCLES(IFG), .MAX_BYTES(1472),
                 .TIMEOUT_CYCLES(TO)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .ch0_req(fp_req0), .ch0_byte_num(ch0_byte_num), .ch0_des_mac(ch0_des_mac), .ch0_data(ch0_data),
    .ch0_rd_en(fp_rd0), .ch0_done(fp_done0), .ch0_err(fp_err0),
    .ch1_req(fp_req1), .ch1_byte_num(ch1_byte_num), .ch1_des_mac(ch1_des_mac), .ch1_data(ch1_data),
    .ch1_rd_en(fp_rd1), .ch1_done(fp_done1), .ch1_err(fp_err1),
    .eng(fp_if), .grant(fp_grant), .busy(fp_busy)
  );

  typedef struct packed {
    logic [1:0]  grant;
    logic        ok;
  } exp_t;

  typedef struct packed {
    logic [1:0]  mask;
    logic [15:0] b0;
    logic [15:0] b1;
    logic [47:0] m0;
    logic [47:0] m1;
    logic [1:0]  g;
    logic        ok;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] byte_q[$];
  vec_t       vecs[5];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap_check();
    int   n = 0;
    logic bad = 1'b0;
    while (busy && n < 100) begin
      bad |= (grant != 2'b00);
      n++;
      tick();
    end
    check("gap_len", n, IFG);
    check("gap_grant", bad, 1'b0);
  endtask

  // Raise the masked requests from IDLE, act as engine + buffer, and check the whole frame.
  task automatic frame(input logic [1:0] mask, input logic [1:0] exp_g, input logic exp_ok);
    exp_t       e;
    int         n, nb, pulses;
    logic       seen_start, rd_seen;
    logic [7:0] v0;
    exp_q.push_back({exp_g, exp_ok});
    ch0_req    = mask[0];
    ch1_req    = mask[1];
    eif.tx_req = ~exp_ok;
    seen_start = 1'b0;
    rd_seen    = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      seen_start |= eif.tx_start_en;
      rd_seen    |= ch0_rd_en | ch1_rd_en;
    end while (grant == 2'b00 && {ch1_err, ch0_err} == 2'b00 && n < 10);
    check("arb_wait", n < 10, 1'b1);
    e = exp_q.pop_front();
    if (e.ok) begin
      check("grant", grant, e.grant);
      n = 0;
      while (eif.tx_start_en && n < 20) begin
        n++;
        tick();
      end
      check("start_len", n, HOLD);
      check("tx_byte_num", eif.tx_byte_num, e.grant[1] ? ch1_byte_num : ch0_byte_num);
      check("des_mac", eif.des_mac, e.grant[1] ? ch1_des_mac : ch0_des_mac);
      nb = int'(e.grant[1] ? ch1_byte_num : ch0_byte_num);
      pulses = 0;
      n = 0;
      while (pulses < nb && n < 4 * nb + 10) begin
        v0 = 8'($urandom);
        ch0_data = v0;
        ch1_data = ~v0;
        byte_q.push_back(e.grant[1] ? ~v0 : v0);
        eif.tx_req = (n % 3 != 2);
        #1;
        check("rd_en", {ch1_rd_en, ch0_rd_en}, eif.tx_req ? e.grant : 2'b00);
        check("tx_data", eif.tx_data, byte_q.pop_front());
        if (ch0_rd_en || ch1_rd_en) pulses++;
        n++;
        tick();
      end
      check("rd_pulses", pulses, nb);
      eif.tx_req  = 1'b0;
      eif.tx_done = 1'b1;
      tick();
      eif.tx_done = 1'b0;
      check("done", {ch1_done, ch0_done}, e.grant);
      check("no_err", {ch1_err, ch0_err}, 2'b00);
      check("grant_drop", grant, 2'b00);
    end else begin
      check("reject_err", {ch1_err, ch0_err}, e.grant);
      check("reject_no_start", seen_start, 1'b0);
      check("reject_no_rd", rd_seen, 1'b0);
      check("reject_grant", grant, 2'b00);
    end
    ch0_req    = 1'b0;
    ch1_req    = 1'b0;
    eif.tx_req = 1'b0;
    gap_check();
  endtask

  task automatic wait_grant();
    int n = 0;
    do begin
      tick();
      n++;
    end while (grant == 2'b00 && n < 10);
    check("grant_wait", n < 10, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    ch0_req = 1'b0; ch1_req = 1'b0; fp_req0 = 1'b0; fp_req1 = 1'b0;
    ch0_byte_num = 16'd4; ch1_byte_num = 16'd4;
    ch0_des_mac = 48'h0; ch1_des_mac = 48'h0;
    ch0_data = 8'h00; ch1_data = 8'h00;
    eif.tx_req = 1'b0; eif.tx_done = 1'b0;
    fp_if.tx_req = 1'b0; fp_if.tx_done = 1'b0;
    repeat (3) tick();
    check("rst_ctrl", {grant, busy, eif.tx_start_en, ch0_done, ch1_done, ch0_err, ch1_err}, 0);
    check("rst_hdr", {eif.tx_byte_num, eif.des_mac}, 0);
    rst_n = 1'b1;
    tick();

    // Both channels request together every frame: round-robin alternates.
    ch0_des_mac = 48'h0A0B0C0D0E0F;
    ch1_des_mac = 48'h102030405060;
    for (int f = 0; f < 4; f++) frame(2'b11, (f % 2 == 0) ? 2'b01 : 2'b10, 1'b1);

    // Fixed-priority instance: ch0 wins every simultaneous request.
    for (int f = 0; f < 2; f++) begin
      fp_req0 = 1'b1;
      fp_req1 = 1'b1;
      n = 0;
      do begin tick(); n++; end while (fp_grant == 2'b00 && n < 10);
      check("fp_grant", fp_grant, 2'b01);
      check("fp_hdr", {fp_if.tx_byte_num, fp_if.des_mac}, {ch0_byte_num, ch0_des_mac});
      check("fp_data", fp_if.tx_data, ch0_data);
      n = 0;
      while (fp_if.tx_start_en && n < 20) begin tick(); n++; end
      fp_if.tx_done = 1'b1;
      tick();
      fp_if.tx_done = 1'b0;
      check("fp_done", {fp_done1, fp_done0}, 2'b01);
      check("fp_quiet", {fp_err1, fp_err0, fp_rd1, fp_rd0}, 4'b0);
      fp_req0 = 1'b0;
      fp_req1 = 1'b0;
      n = 0;
      while (fp_busy && n < 50) begin tick(); n++; end
      check("fp_idle", fp_busy, 1'b0);
    end

    vecs[0] = '{mask: 2'b01, b0: 16'd32,   b1: 16'd0,    m0: 48'h001122334455, m1: 48'h0,            g: 2'b01, ok: 1'b1};
    vecs[1] = '{mask: 2'b10, b0: 16'd0,    b1: 16'd0,    m0: 48'h0,            m1: 48'h665544332211, g: 2'b10, ok: 1'b0};
    vecs[2] = '{mask: 2'b10, b0: 16'd0,    b1: 16'd1473, m0: 48'h0,            m1: 48'h665544332211, g: 2'b10, ok: 1'b0};
    vecs[3] = '{mask: 2'b10, b0: 16'd0,    b1: 16'd1472, m0: 48'h0,            m1: 48'hAABBCCDDEEFF, g: 2'b10, ok: 1'b1};
    vecs[4] = '{mask: 2'b01, b0: 16'd1,    b1: 16'd0,    m0: 48'h0,            m1: 48'h0,            g: 2'b01, ok: 1'b1};
    for (int i = 0; i < 5; i++) begin
      ch0_byte_num = vecs[i].b0;
      ch1_byte_num = vecs[i].b1;
      ch0_des_mac  = vecs[i].m0;
      ch1_des_mac  = vecs[i].m1;
      frame(vecs[i].mask, vecs[i].g, vecs[i].ok);
    end

    // Hung engine: error exactly TO cycles after START entry, then ch1 is served.
    ch0_byte_num = 16'd32;
    ch0_req = 1'b1;
    wait_grant();
    check("to_grant", grant, 2'b01);
    n = 0;
    while ({ch1_err, ch0_err} == 2'b00 && n < TO + 100) begin tick(); n++; end
    check("to_cycles", n, TO);
    check("to_err", {ch1_err, ch0_err}, 2'b01);
    check("to_no_done", {ch1_done, ch0_done}, 2'b00);
    ch0_req = 1'b0;
    gap_check();
    ch1_byte_num = 16'd18;
    frame(2'b10, 2'b10, 1'b1);

    // Completion on the very expiry cycle wins over the timeout.
    ch0_req = 1'b1;
    wait_grant();
    repeat (TO - 1) tick();
    eif.tx_done = 1'b1;
    tick();
    eif.tx_done = 1'b0;
    check("race_done", {ch1_done, ch0_done}, 2'b01);
    check("race_err", {ch1_err, ch0_err}, 2'b00);
    ch0_req = 1'b0;
    gap_check();

    // Asynchronous reset in the middle of a frame.
    ch0_req = 1'b1;
    wait_grant();
    repeat (6) tick();
    eif.tx_req = 1'b1;
    #1;
    check("pre_rst_rd", ch0_rd_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {grant, busy, eif.tx_start_en, ch0_rd_en, ch1_rd_en, ch0_done, ch1_done, ch0_err, ch1_err}, 0);
    check("mid_rst_data", {eif.tx_data, eif.tx_byte_num, eif.des_mac}, 0);
    ch0_req = 1'b0;
    eif.tx_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ch1_byte_num = 16'd18;
    ch1_des_mac  = 48'h020000000001;
    frame(2'b10, 2'b10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
